// File: rtl/addsub_acc5.sv
// addsub_acc5: registered 5-bit accumulator wrapped around an external
// combinational 5-bit add/sub stage. Commands (ADD/SUB/LOAD/CLEAR) arrive on
// a valid/ready port, execute for one cycle against the stage, and the result
// is held on a valid/ready result port until consumed.
//
// Optional feature macro: ADDSUB_ACC_SAT_EN
//   defined   -> ADD/SUB results that overflow saturate to 01111 / 10000
//   undefined -> ADD/SUB results wrap (stage sum taken as-is)
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         command handshake
//   in_op[1:0], in_data[4:0]  command: 00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
//   as_sub, as_a, as_b        operands/select driven to the add/sub stage
//   as_z, as_co, as_oflow     sum, carry-out, overflow from the add/sub stage
//   acc, acc_co, acc_ovf      accumulator, last carry, sticky overflow
//   out_valid/out_ready       result handshake
//   op_cnt[CNT_W-1:0]         completed-operation counter (wraps)
module addsub_acc5 #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [4:0]       in_data,
  output logic             as_sub,
  output logic [4:0]       as_a,
  output logic [4:0]       as_b,
  input  logic [4:0]       as_z,
  input  logic             as_co,
  input  logic             as_oflow,
  output logic [4:0]       acc,
  output logic             acc_co,
  output logic             acc_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] op_cnt
);

  localparam int unsigned DW = 5;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [1:0]       r_op;
  logic [DW-1:0]    r_opnd;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_as_sub;
  logic [DW-1:0]    r_acc;
  logic             r_acc_co;
  logic             r_acc_ovf;
  logic [CNT_W-1:0] r_op_cnt;

  logic             w_accept;
  logic [1:0]       w_op_nxt;
  logic [DW-1:0]    w_opnd_nxt;
  logic             w_in_ready_nxt;
  logic             w_out_valid_nxt;
  logic             w_as_sub_nxt;
  logic [DW-1:0]    w_sum_sel;
  logic [DW-1:0]    w_acc_nxt;
  logic             w_acc_co_nxt;
  logic             w_acc_ovf_nxt;
  logic [CNT_W-1:0] w_op_cnt_nxt;

  // in_ready is a flop that mirrors "state is IDLE", so it can gate accept.
  assign w_accept = in_valid & r_in_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_HOLD;
      S_HOLD:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered handshake/stage outputs,
  // decoded from the next state so they are valid in the cycle they apply.
  always_comb begin
    w_op_nxt        = r_op;
    w_opnd_nxt      = r_opnd;
    if (w_accept) begin
      w_op_nxt   = in_op;
      w_opnd_nxt = in_data;
    end
    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
    w_out_valid_nxt = (w_state_nxt == S_HOLD);
    w_as_sub_nxt    = (w_state_nxt == S_EXEC) && (w_op_nxt == OP_SUB);
  end

  // Stage result selection; saturation clamps toward the sign of operand a,
  // which is the only operand whose sign an overflow can be judged against here.
`ifdef ADDSUB_ACC_SAT_EN
  assign w_sum_sel = as_oflow ? (r_acc[DW-1] ? 5'b10000 : 5'b01111) : as_z;
`else
  assign w_sum_sel = as_z;
`endif

  // Accumulator datapath: only EXEC changes architectural state.
  always_comb begin
    w_acc_nxt     = r_acc;
    w_acc_co_nxt  = r_acc_co;
    w_acc_ovf_nxt = r_acc_ovf;
    w_op_cnt_nxt  = r_op_cnt;
    if (r_state == S_EXEC) begin
      w_op_cnt_nxt = r_op_cnt + CNT_W'(1);
      unique case (r_op)
        OP_ADD, OP_SUB: begin
          w_acc_nxt     = w_sum_sel;
          w_acc_co_nxt  = as_co;
          w_acc_ovf_nxt = r_acc_ovf | as_oflow;
        end
        OP_LOAD: begin
          w_acc_nxt    = r_opnd;
          w_acc_co_nxt = 1'b0;
        end
        OP_CLEAR: begin
          w_acc_nxt     = '0;
          w_acc_co_nxt  = 1'b0;
          w_acc_ovf_nxt = 1'b0;
        end
        default: begin
          w_acc_nxt = r_acc;
        end
      endcase
    end
  end

  // Output, command and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op        <= OP_ADD;
      r_opnd      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_as_sub    <= 1'b0;
      r_acc       <= '0;
      r_acc_co    <= 1'b0;
      r_acc_ovf   <= 1'b0;
      r_op_cnt    <= '0;
    end else begin
      r_op        <= w_op_nxt;
      r_opnd      <= w_opnd_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_as_sub    <= w_as_sub_nxt;
      r_acc       <= w_acc_nxt;
      r_acc_co    <= w_acc_co_nxt;
      r_acc_ovf   <= w_acc_ovf_nxt;
      r_op_cnt    <= w_op_cnt_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign as_sub    = r_as_sub;
  assign as_a      = r_acc;
  assign as_b      = r_opnd;
  assign acc       = r_acc;
  assign acc_co    = r_acc_co;
  assign acc_ovf   = r_acc_ovf;
  assign op_cnt    = r_op_cnt;

endmodule

// File: tb/tb_addsub_acc5.sv
// tb_addsub_acc5: directed self-checking bench for addsub_acc5. Includes a
// behavioural model of the external combinational 5-bit add/sub stage.
module tb_addsub_acc5;

  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [4:0]       in_data;
  logic             as_sub;
  logic [4:0]       as_a;
  logic [4:0]       as_b;
  logic [4:0]       as_z;
  logic             as_co;
  logic             as_oflow;
  logic [4:0]       acc;
  logic             acc_co;
  logic             acc_ovf;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] op_cnt;

  int n_tests;
  int n_fail;
  int exp_cnt;

  addsub_acc5 #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .as_sub    (as_sub),
    .as_a      (as_a),
    .as_b      (as_b),
    .as_z      (as_z),
    .as_co     (as_co),
    .as_oflow  (as_oflow),
    .acc       (acc),
    .acc_co    (acc_co),
    .acc_ovf   (acc_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op_cnt    (op_cnt)
  );

  // Add/sub stage: a + (sub ? ~b + 1 : b).
  logic [4:0] st_bx;
  logic [5:0] st_sum;
  assign st_bx    = as_sub ? ~as_b : as_b;
  assign st_sum   = {1'b0, as_a} + {1'b0, st_bx} + 6'(as_sub);
  assign as_z     = st_sum[4:0];
  assign as_co    = st_sum[5];
  assign as_oflow = (as_a[4] == st_bx[4]) && (st_sum[4] != as_a[4]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // Called at a negedge; returns at the negedge after the accepting edge (EXEC).
  task automatic send_cmd(input logic [1:0] op, input logic [4:0] d);
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    @(posedge clk);
    #1 in_valid = 1'b0;
    exp_cnt = (exp_cnt + 1) % 256;
    @(negedge clk);
  endtask

  task automatic wait_hold();
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_timeout: out_valid=%b required 1", out_valid);
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_op = 2'b00; in_data = 5'd0; out_ready = 1'b0;
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({in_ready, out_valid, as_sub} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_hs: {in_ready,out_valid,as_sub}=%b required 100", {in_ready, out_valid, as_sub});
    end
    n_tests++;
    if ({acc, acc_co, acc_ovf, as_a, as_b} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_data: acc=%b co=%b ovf=%b a=%b b=%b required all 0", acc, acc_co, acc_ovf, as_a, as_b);
    end
    n_tests++;
    if (op_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: op_cnt=%0d required 0", op_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_sub();
    send_cmd(OP_LOAD, 5'd3);
    wait_hold();
    n_tests++;
    if (acc !== 5'd3 || acc_co !== 1'b0) begin
      n_fail++;
      $display("FAIL load3: acc=%b co=%b required 00011 0", acc, acc_co);
    end
    release_result();
    send_cmd(OP_SUB, 5'd5);
    n_tests++;
    if ({as_sub, as_a, as_b, in_ready, out_valid} !== {1'b1, 5'd3, 5'd5, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL sub_exec: sub=%b a=%b b=%b in_ready=%b out_valid=%b required 1 00011 00101 0 0",
               as_sub, as_a, as_b, in_ready, out_valid);
    end
    wait_hold();
    n_tests++;
    if (acc !== 5'b11110 || acc_co !== 1'b0 || acc_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL sub5: acc=%b co=%b ovf=%b required 11110 0 0", acc, acc_co, acc_ovf);
    end
    n_tests++;
    if (op_cnt !== 8'd2 || as_sub !== 1'b0) begin
      n_fail++;
      $display("FAIL sub5_cnt: op_cnt=%0d as_sub=%b required 2 0", op_cnt, as_sub);
    end
    release_result();
  endtask

  task automatic test_carry();
    send_cmd(OP_LOAD, 5'd7);
    wait_hold();
    release_result();
    send_cmd(OP_SUB, 5'd2);
    wait_hold();
    n_tests++;
    if (acc !== 5'd5 || acc_co !== 1'b1 || acc_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_noborrow: acc=%b co=%b ovf=%b required 00101 1 0", acc, acc_co, acc_ovf);
    end
    release_result();
  endtask

  task automatic test_overflow();
    send_cmd(OP_LOAD, 5'd10);
    wait_hold();
    release_result();
    send_cmd(OP_ADD, 5'd9);
    wait_hold();
    n_tests++;
`ifdef ADDSUB_ACC_SAT_EN
    if (acc !== 5'b01111 || acc_co !== 1'b0 || acc_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL add_ovf: acc=%b co=%b ovf=%b required 01111 0 1", acc, acc_co, acc_ovf);
    end
`else
    if (acc !== 5'b10011 || acc_co !== 1'b0 || acc_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL add_ovf: acc=%b co=%b ovf=%b required 10011 0 1", acc, acc_co, acc_ovf);
    end
`endif
    release_result();
    send_cmd(OP_ADD, 5'd1);
    wait_hold();
    n_tests++;
`ifdef ADDSUB_ACC_SAT_EN
    if (acc !== 5'b01111 || acc_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: acc=%b ovf=%b required 01111 1", acc, acc_ovf);
    end
`else
    if (acc !== 5'b10100 || acc_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: acc=%b ovf=%b required 10100 1", acc, acc_ovf);
    end
`endif
    release_result();
    send_cmd(OP_CLEAR, 5'd21);
    wait_hold();
    n_tests++;
    if (acc !== 5'd0 || acc_co !== 1'b0 || acc_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL clear: acc=%b co=%b ovf=%b required 00000 0 0", acc, acc_co, acc_ovf);
    end
    n_tests++;
    if (op_cnt !== CNT_W'(exp_cnt)) begin
      n_fail++;
      $display("FAIL clear_cnt: op_cnt=%0d required %0d", op_cnt, exp_cnt);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    send_cmd(OP_LOAD, 5'd7);
    wait_hold();
    in_valid = 1'b1;
    in_op    = OP_CLEAR;
    in_data  = 5'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || acc !== 5'b00111 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: out_valid=%b acc=%b in_ready=%b required 1 00111 0",
                 i, out_valid, acc, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || acc !== 5'b00111 || op_cnt !== CNT_W'(exp_cnt)) begin
      bad = 1;
    end
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b acc=%b op_cnt=%0d required 0 1 00111 %0d",
               out_valid, in_ready, acc, op_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_exec();
    send_cmd(OP_ADD, 5'd4);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({in_ready, out_valid, as_sub, acc, acc_co, acc_ovf, as_a, as_b} !== {1'b1, 19'd0}) begin
      n_fail++;
      $display("FAIL rst_exec: rdy=%b ov=%b sub=%b acc=%b co=%b ovf=%b a=%b b=%b required 1 0 0 0 0 0 0 0",
               in_ready, out_valid, as_sub, acc, acc_co, acc_ovf, as_a, as_b);
    end
    n_tests++;
    if (op_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_exec_cnt: op_cnt=%0d required 0", op_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || op_cnt !== 8'd0 || acc !== 5'd0) begin
        n_fail++;
        $display("FAIL rst_after[%0d]: out_valid=%b op_cnt=%0d acc=%b required 0 0 00000",
                 i, out_valid, op_cnt, acc);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] e_acc;
    logic       e_ovf;
    out_ready = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      send_cmd(OP_ADD, 5'd1);
      wait_hold();
`ifdef ADDSUB_ACC_SAT_EN
      e_acc = (i < 16) ? 5'(i) : 5'b01111;
`else
      e_acc = 5'(i);
`endif
      e_ovf = (i >= 16);
      n_tests++;
      if (acc !== e_acc || acc_ovf !== e_ovf) begin
        n_fail++;
        $display("FAIL b2b[%0d]: acc=%b ovf=%b required %b %b", i, acc, acc_ovf, e_acc, e_ovf);
      end
`ifndef ADDSUB_ACC_SAT_EN
      if (i == 32) begin
        n_tests++;
        if (acc_co !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_carry: acc_co=%b required 1", acc_co);
        end
      end
`endif
      if (i == 255) begin
        n_tests++;
        if (op_cnt !== 8'd255) begin
          n_fail++;
          $display("FAIL b2b_cnt255: op_cnt=%0d required 255", op_cnt);
        end
      end
    end
    n_tests++;
    if (op_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL b2b_wrap: op_cnt=%0d required 0", op_cnt);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_cnt = 0;
    test_reset();
    test_load_sub();
    test_carry();
    test_overflow();
    test_backpressure();
    test_reset_mid_exec();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
